// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with one-entry fetch buffer and redirect handling
// Optional stall counter enabled by FETCH_PERF_EN.
module fetch_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic        instr_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

   state_t      state, state_nx;
   logic [31:0] fa, fa_nx;
   logic [31:0] redir_tgt, redir_tgt_nx;
   logic        redir_pend, redir_pend_nx;
   logic [31:0] instr_nx, pc_nx;
   logic        valid_nx;
   logic        acc, consume, load;

   assign acc       = !instr_valid || !stall;
   assign consume   = instr_valid && !stall;
   assign imem_req  = ((state == FETCH) && acc) || (state == WAIT);
   assign imem_addr = fa;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         fa          <= RESET_PC;
         redir_pend  <= 1'b0;
         redir_tgt   <= 32'h0;
         instr       <= 32'h0;
         pc_out      <= RESET_PC;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_nx;
         fa          <= fa_nx;
         redir_pend  <= redir_pend_nx;
         redir_tgt   <= redir_tgt_nx;
         instr       <= instr_nx;
         pc_out      <= pc_nx;
         instr_valid <= valid_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      fa_nx         = fa;
      redir_pend_nx = redir_pend;
      redir_tgt_nx  = redir_tgt;
      load          = 1'b0;
      case (state)
         IDLE: begin
            state_nx = FETCH;
            if (br_valid) fa_nx = br_target;
         end
         FETCH: begin
            if (!imem_req) begin
               if (br_valid) fa_nx = br_target;
            end else if (imem_ack) begin
               if (br_valid) begin
                  fa_nx = br_target;
               end else begin
                  load  = 1'b1;
                  fa_nx = fa + 32'd4;
               end
            end else begin
               // Request stays outstanding: a redirect must wait for the ack.
               state_nx = WAIT;
               if (br_valid) begin
                  redir_pend_nx = 1'b1;
                  redir_tgt_nx  = br_target;
               end
            end
         end
         WAIT: begin
            if (imem_ack) begin
               state_nx      = FETCH;
               redir_pend_nx = 1'b0;
               if (br_valid) begin
                  fa_nx = br_target;
               end else if (redir_pend) begin
                  fa_nx = redir_tgt;
               end else begin
                  load  = 1'b1;
                  fa_nx = fa + 32'd4;
               end
            end else if (br_valid) begin
               redir_pend_nx = 1'b1;
               redir_tgt_nx  = br_target;
            end
         end
         default: state_nx = IDLE;
      endcase

      valid_nx = instr_valid;
      instr_nx = instr;
      pc_nx    = pc_out;
      if (br_valid) begin
         valid_nx = 1'b0;
      end else if (load) begin
         valid_nx = 1'b1;
         instr_nx = imem_rdata;
         pc_nx    = fa;
      end else if (consume) begin
         valid_nx = 1'b0;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= 32'h0;
      end else if (instr_valid && stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        instr_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int tests = 0;
   int fails = 0;

   localparam logic [31:0] BAD = 32'hDEAD_BEEF;

   fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .pc_out     (pc_out),
      .instr_valid(instr_valid)
`ifdef FETCH_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b1; br_valid = 1'b1; br_target = 32'h5000;
      imem_ack = 1'b1; imem_rdata = BAD;
      tick(); tick();
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL reset_addr: got %h expected 00003000", imem_addr); end
      tests++; if (pc_out !== 32'h3000) begin fails++; $display("FAIL reset_pc: got %h expected 00003000", pc_out); end
      tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h expected 0", instr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
`ifdef FETCH_PERF_EN
      tests++; if (stall_cnt !== 32'h0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
      stall = 1'b0; br_valid = 1'b0; imem_ack = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      do_reset();
      imem_ack = 1'b1;
      #1;
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stream_idle_req: got %b expected 0", imem_req); end
      tick();
      for (int i = 0; i < 3; i++) begin
         exp = 32'h3000 + 32'(4 * i);
         imem_rdata = 32'hC000_0000 | exp;
         #1;
         tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL stream_req[%0d]: got %b expected 1", i, imem_req); end
         tests++; if (imem_addr !== exp) begin fails++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, imem_addr, exp); end
         tick();
         tests++; if (instr !== (32'hC000_0000 | exp)) begin fails++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, instr, 32'hC000_0000 | exp); end
         tests++; if (pc_out !== exp) begin fails++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pc_out, exp); end
         tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, instr_valid); end
      end
   endtask

   task automatic test_wait();
      do_reset();
      tick();
      imem_ack = 1'b1; imem_rdata = 32'hC000_3000;
      tick();
      imem_ack = 1'b0; imem_rdata = BAD;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin imem_ack = 1'b1; imem_rdata = 32'hC000_3004; end
         #1;
         tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL wait_req[%0d]: got %b expected 1", i, imem_req); end
         tests++; if (imem_addr !== 32'h3004) begin fails++; $display("FAIL wait_addr[%0d]: got %h expected 00003004", i, imem_addr); end
         if (i > 0) begin
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL wait_valid[%0d]: got %b expected 0", i, instr_valid); end
         end
         tick();
      end
      tests++; if (instr !== 32'hC000_3004) begin fails++; $display("FAIL wait_instr: got %h expected c0003004", instr); end
      tests++; if (pc_out !== 32'h3004) begin fails++; $display("FAIL wait_pc: got %h expected 00003004", pc_out); end
      tests++; if (imem_addr !== 32'h3008) begin fails++; $display("FAIL wait_next_addr: got %h expected 00003008", imem_addr); end
      imem_ack = 1'b0; stall = 1'b1; imem_rdata = BAD;
      tick();
      tests++; if (instr !== 32'hC000_3004) begin fails++; $display("FAIL wait_single_load: got %h expected c0003004", instr); end
      stall = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      imem_ack = 1'b1; imem_rdata = 32'hC000_3000;
      tick();
      imem_rdata = BAD; stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
         tests++; if (instr !== 32'hC000_3000) begin fails++; $display("FAIL stall_instr[%0d]: got %h expected c0003000", i, instr); end
         tests++; if (pc_out !== 32'h3000) begin fails++; $display("FAIL stall_pc[%0d]: got %h expected 00003000", i, pc_out); end
         tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); end
         tick();
      end
      stall = 1'b0; imem_rdata = 32'hC000_3004;
`ifdef FETCH_PERF_EN
      tests++; if (stall_cnt !== 32'd4) begin fails++; $display("FAIL stall_cnt: got %0d expected 4", stall_cnt); end
`endif
      #1;
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL stall_release_req: got %b expected 1", imem_req); end
      tick();
      tests++; if (instr !== 32'hC000_3004) begin fails++; $display("FAIL stall_next_instr: got %h expected c0003004", instr); end
      tests++; if (pc_out !== 32'h3004) begin fails++; $display("FAIL stall_next_pc: got %h expected 00003004", pc_out); end
      imem_ack = 1'b0;
   endtask

   task automatic test_redirect_fetch();
      do_reset();
      tick();
      imem_ack = 1'b1; imem_rdata = 32'hC000_3000;
      tick();
      stall = 1'b1; br_valid = 1'b1; br_target = 32'h4000; imem_rdata = BAD;
      tick();
      br_valid = 1'b0;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL brf_stall_valid: got %b expected 0", instr_valid); end
      tests++; if (imem_addr !== 32'h4000) begin fails++; $display("FAIL brf_stall_addr: got %h expected 00004000", imem_addr); end
      stall = 1'b0; imem_rdata = 32'hC000_4000;
      tick();
      tests++; if (instr !== 32'hC000_4000) begin fails++; $display("FAIL brf_instr: got %h expected c0004000", instr); end
      tests++; if (pc_out !== 32'h4000) begin fails++; $display("FAIL brf_pc: got %h expected 00004000", pc_out); end
      br_valid = 1'b1; br_target = 32'h4100; imem_rdata = BAD;
      tick();
      br_valid = 1'b0;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL brf_ack_valid: got %b expected 0", instr_valid); end
      tests++; if (imem_addr !== 32'h4100) begin fails++; $display("FAIL brf_ack_addr: got %h expected 00004100", imem_addr); end
      imem_rdata = 32'hC000_4100;
      tick();
      tests++; if (pc_out !== 32'h4100) begin fails++; $display("FAIL brf_ack_pc: got %h expected 00004100", pc_out); end
      tests++; if (instr !== 32'hC000_4100) begin fails++; $display("FAIL brf_ack_instr: got %h expected c0004100", instr); end
      imem_ack = 1'b0;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      tick();
      imem_ack = 1'b0;
      tick();
      br_valid = 1'b1; br_target = 32'h3100;
      tick();
      br_valid = 1'b0;
      #1;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL brw_valid1: got %b expected 0", instr_valid); end
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL brw_req: got %b expected 1", imem_req); end
      tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL brw_addr_hold: got %h expected 00003000", imem_addr); end
      tick();
      imem_ack = 1'b1; imem_rdata = BAD;
      tick();
      imem_ack = 1'b0;
      #1;
      tests++; if (imem_addr !== 32'h3100) begin fails++; $display("FAIL brw_addr: got %h expected 00003100", imem_addr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL brw_discard: got %b expected 0", instr_valid); end
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL brw_req2: got %b expected 1", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'hC000_3100;
      tick();
      tests++; if (pc_out !== 32'h3100) begin fails++; $display("FAIL brw_pc: got %h expected 00003100", pc_out); end
      tests++; if (instr !== 32'hC000_3100) begin fails++; $display("FAIL brw_instr: got %h expected c0003100", instr); end
      imem_ack = 1'b0;
   endtask

   task automatic test_redirect_overwrite();
      do_reset();
      tick();
      imem_ack = 1'b0;
      tick();
      br_valid = 1'b1; br_target = 32'h3200;
      tick();
      br_target = 32'h3300;
      tick();
      br_valid = 1'b0; imem_ack = 1'b1; imem_rdata = BAD;
      #1;
      tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL bro_addr_hold: got %h expected 00003000", imem_addr); end
      tick();
      imem_ack = 1'b0;
      tests++; if (imem_addr !== 32'h3300) begin fails++; $display("FAIL bro_addr: got %h expected 00003300", imem_addr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL bro_valid: got %b expected 0", instr_valid); end
      imem_ack = 1'b1; imem_rdata = 32'hC000_3300;
      tick();
      tests++; if (pc_out !== 32'h3300) begin fails++; $display("FAIL bro_pc: got %h expected 00003300", pc_out); end
      imem_ack = 1'b0;
   endtask

   task automatic test_reset_wait();
      do_reset();
      tick();
      imem_ack = 1'b1; imem_rdata = 32'hC000_3000;
      tick();
      imem_ack = 1'b0;
      tick();
      #1;
      tests++; if (imem_addr !== 32'h3004) begin fails++; $display("FAIL rw_wait_addr: got %h expected 00003004", imem_addr); end
      reset = 1'b0;
      tick();
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_req: got %b expected 0", imem_req); end
      tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL rw_addr: got %h expected 00003000", imem_addr); end
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = BAD;
      tick();
      #1;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rw_orphan_valid: got %b expected 0", instr_valid); end
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rw_fetch_req: got %b expected 1", imem_req); end
      imem_rdata = 32'hC000_3000;
      tick();
      tests++; if (instr !== 32'hC000_3000) begin fails++; $display("FAIL rw_instr: got %h expected c0003000", instr); end
      tests++; if (pc_out !== 32'h3000) begin fails++; $display("FAIL rw_pc: got %h expected 00003000", pc_out); end
      imem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait();
      test_stall();
      test_redirect_fetch();
      test_redirect_wait();
      test_redirect_overwrite();
      test_reset_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low; reset==0 at a rising clk edge resets the block.
REQ-003 SHALL have: stall  in  1  downstream hold; buffered instruction not consumed this cycle.
REQ-004 SHALL have: br_valid  in  1  redirect request, single-cycle; br_target  in  32  redirect address.
REQ-005 SHALL have: imem_req  out  1 and imem_addr  out  32, the instruction-memory request.
REQ-006 SHALL have: imem_ack  in  1 and imem_rdata  in  32, the response; ack one or more cycles after req.
REQ-007 SHALL have: instr  out  32, pc_out  out  32, instr_valid  out  1, a one-entry fetch buffer.
REQ-008 SHALL have, only under FETCH_PERF_EN: stall_cnt  out  32.

Function
REQ-009 SHALL hold fetch address fa (32b), state {IDLE, FETCH, WAIT}, redir_pend (1b), redir_tgt (32b).
REQ-010 SHALL drive imem_addr = fa at all times.
REQ-011 SHALL define acc = !instr_valid || !stall; consume = instr_valid && !stall.
REQ-012 SHALL set imem_req = (FETCH && acc) || WAIT.
REQ-013 IDLE: imem_req=0; next state FETCH unconditionally.
REQ-014 FETCH, imem_req=1, imem_ack=1, no redirect: buffer <= {imem_rdata, fa, valid=1}; fa <= fa+4 (mod 2^32); stay FETCH.
REQ-015 FETCH, imem_req=1, imem_ack=0: go WAIT; fa and imem_addr SHALL stay constant until ack.
REQ-016 WAIT, imem_ack=1, no redirect pending/arriving: load buffer as REQ-014; go FETCH.
REQ-017 A new request SHALL issue only when acc; the buffer is therefore always free at ack.
REQ-018 consume without load SHALL clear instr_valid; consume with load SHALL replace buffer contents, instr_valid stays 1.
REQ-019 stall with instr_valid=1 SHALL hold instr, pc_out, instr_valid unchanged.
REQ-020 br_valid=1 SHALL clear instr_valid next cycle, overriding stall and any load.
REQ-021 br_valid with no request outstanding (IDLE, or FETCH with imem_req=0): fa <= br_target next cycle.
REQ-022 br_valid with FETCH req and ack same cycle, or WAIT with ack: discard rdata; fa <= br_target; go FETCH.
REQ-023 br_valid with request outstanding and no ack: redir_pend<=1, redir_tgt<=br_target, go/stay WAIT, fa unchanged.
REQ-024 WAIT, ack, redir_pend=1: discard rdata; fa <= redir_tgt; redir_pend<=0; go FETCH.
REQ-025 br_valid while redir_pend=1: newer br_target overwrites redir_tgt.
REQ-026 imem_ack while imem_req=0 SHALL be ignored.
REQ-027 A request SHALL reach the buffer exactly one cycle after ack (registered outputs).

Reset
REQ-028 On reset==0: state=IDLE, fa=0x0000_3000, pc_out=0x0000_3000, instr=0, instr_valid=0, redir_pend=0, redir_tgt=0, stall_cnt=0.
REQ-029 Reset mid-WAIT SHALL drop imem_req the next cycle; the orphaned ack is ignored per REQ-026.
REQ-030 reset SHALL take priority over br_valid, stall and imem_ack.

Configuration
REQ-031 Macro FETCH_PERF_EN defined: stall_cnt increments by 1 each cycle with instr_valid && stall, wrapping at 2^32.
REQ-032 Macro FETCH_PERF_EN undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset low 2 cycles, release, ack same cycle always -> imem_addr 0x3000,0x3004,0x3008; instr_valid from cycle 3 after release.
REQ-034 Ack delayed 3 cycles -> imem_req stays 1, imem_addr stable at 0x3004 through WAIT; one buffer load.
REQ-035 instr_valid=1, stall held 4 cycles -> imem_req=0, instr/pc_out frozen; stall_cnt=4 (with FETCH_PERF_EN).
REQ-036 br_valid target 0x3100 during WAIT, ack 2 cycles later -> rdata discarded, next imem_addr 0x3100, instr_valid=0 meanwhile.
REQ-037 br_valid 0x3200 then 0x3300 before ack -> next request at 0x3300 only.
REQ-038 reset low mid-WAIT, ack next cycle -> no buffer load, imem_addr 0x3000, state IDLE then FETCH.
